// File: rtl/pcie_rx_credit_return.sv
// Receive-side credit return for the PCIe x1 core VC0 interface: parses TLP headers,
// queues each TLP's header/data credit cost and returns it on release.
module pcie_rx_credit_return #(
  parameter int DEPTH        = 8,
  parameter bit AUTO_RELEASE = 1'b0,
  parameter int PH_THRESH    = 6,
  parameter int NPH_THRESH   = 6
) (
  input  logic        sys_clk_125,
  input  logic        rst,
  input  logic [15:0] rx_data_vc0,
  input  logic        rx_st_vc0,
  input  logic        rx_end_vc0,
  input  logic        tlp_release,
  output logic        ph_processed_vc0,
  output logic        nph_processed_vc0,
  output logic        pd_processed_vc0,
  output logic        npd_processed_vc0,
  output logic [7:0]  pd_num_vc0,
  output logic [7:0]  npd_num_vc0,
  output logic        ph_buf_status_vc0,
  output logic        nph_buf_status_vc0,
  output logic        pd_buf_status_vc0,
  output logic        npd_buf_status_vc0,
  output logic        queue_overflow,
  output logic [5:0]  pending_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {HDR_IDLE, HDR_W0, HDR_W1} hdr_state_t;
  typedef enum logic [1:0] {IDLE, RET, RET2} ret_state_t;

  typedef struct packed {
    logic       np;
    logic [8:0] dcred;
  } entry_t;

  hdr_state_t hdr_state;
  logic [1:0] fmt_q;
  logic [4:0] type_q;
  logic [9:0] len_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      hdr_state <= HDR_IDLE;
      fmt_q     <= '0;
      type_q    <= '0;
      len_q     <= '0;
    end else if (rx_st_vc0 && rx_end_vc0) begin
      hdr_state <= HDR_IDLE;
    end else if (rx_st_vc0) begin
      hdr_state <= HDR_W0;
      fmt_q     <= rx_data_vc0[14:13];
      type_q    <= rx_data_vc0[12:8];
    end else if (rx_end_vc0) begin
      hdr_state <= HDR_IDLE;
    end else if (hdr_state == HDR_W0) begin
      hdr_state <= HDR_W1;
      len_q     <= rx_data_vc0[9:0];
    end
  end

  // A TLP that ends on its w1 cycle takes its length straight off the bus.
  logic [9:0]  cur_len;
  logic [10:0] len_eff;
  logic [10:0] dcred_sum;
  logic [8:0]  dcred;
  logic        is_cpl;
  logic        is_np;
  logic        tlp_end;

  assign tlp_end   = rx_end_vc0 && !rx_st_vc0 && (hdr_state != HDR_IDLE);
  assign cur_len   = (hdr_state == HDR_W0) ? rx_data_vc0[9:0] : len_q;
  assign len_eff   = (cur_len == 10'd0) ? 11'd1024 : {1'b0, cur_len};
  assign dcred_sum = len_eff + 11'd3;
  assign dcred     = fmt_q[1] ? dcred_sum[10:2] : 9'd0;
  assign is_cpl    = (type_q[4:1] == 4'b0101);
  assign is_np     = ((type_q == 5'b00000) && !fmt_q[1]) ||
                     ((type_q == 5'b00001) && !fmt_q[1]) ||
                     (type_q == 5'b00010) ||
                     (type_q[4:1] == 4'b0010);

  logic unused_bits;
  assign unused_bits = ^{rx_data_vc0[15], dcred_sum[1:0]};

  // Pending-TLP queue
  entry_t     mem [DEPTH];
  entry_t     head;
  entry_t     new_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [5:0] count, p_cnt, np_cnt;
  logic       full, enq_req, enq, pop_req, pop;
  ret_state_t state, state_next;

  assign full      = (count == 6'(DEPTH));
  assign enq_req   = tlp_end && !is_cpl;
  assign enq       = enq_req && !full;
  assign new_entry = '{np: is_np, dcred: dcred};
  assign head      = mem[rd_ptr];
  assign pop_req   = AUTO_RELEASE ? (count != 6'd0) : tlp_release;
  assign pop       = pop_req && (state == IDLE) && (count != 6'd0);

  // NOTE: queue storage has no reset; the pointers and count define which
  // entries are valid, so clearing the array would only add reset fanout.
  always_ff @(posedge sys_clk_125) begin
    if (enq) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      p_cnt          <= '0;
      np_cnt         <= '0;
      queue_overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {5'd0, enq} - {5'd0, pop};
      p_cnt <= p_cnt + {5'd0, enq && !new_entry.np} - {5'd0, pop && !head.np};
      np_cnt <= np_cnt + {5'd0, enq && new_entry.np} - {5'd0, pop && head.np};
      if (enq_req && full) queue_overflow <= 1'b1;
    end
  end

  assign pending_cnt = count;

  // Return FSM
  entry_t cur;

  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_next;
      if (pop) cur <= head;
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = RET;
      RET:     state_next = (cur.dcred > 9'd255) ? RET2 : IDLE;
      RET2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic       ph_d, nph_d, pd_d, npd_d;
  logic [7:0] pd_num_d, npd_num_d, num_d;

  // Next-cycle outputs, registered below so the core sees clean pulses.
  always_comb begin
    ph_d      = 1'b0;
    nph_d     = 1'b0;
    pd_d      = 1'b0;
    npd_d     = 1'b0;
    num_d     = 8'd0;
    pd_num_d  = 8'd0;
    npd_num_d = 8'd0;
    case (state)
      IDLE: begin
        if (pop) begin
          ph_d  = !head.np;
          nph_d = head.np;
          num_d = (head.dcred > 9'd255) ? 8'd255 : head.dcred[7:0];
          if (head.dcred != 9'd0) begin
            pd_d  = !head.np;
            npd_d = head.np;
          end
        end
      end
      RET: begin
        if (cur.dcred > 9'd255) begin
          num_d = 8'(cur.dcred - 9'd255);
          pd_d  = !cur.np;
          npd_d = cur.np;
        end
      end
      default: ;
    endcase
    if (pd_d)  pd_num_d  = num_d;
    if (npd_d) npd_num_d = num_d;
  end

  always_ff @(posedge sys_clk_125) begin
    if (rst) begin
      ph_processed_vc0   <= 1'b0;
      nph_processed_vc0  <= 1'b0;
      pd_processed_vc0   <= 1'b0;
      npd_processed_vc0  <= 1'b0;
      pd_num_vc0         <= '0;
      npd_num_vc0        <= '0;
      ph_buf_status_vc0  <= 1'b0;
      nph_buf_status_vc0 <= 1'b0;
    end else begin
      ph_processed_vc0   <= ph_d;
      nph_processed_vc0  <= nph_d;
      pd_processed_vc0   <= pd_d;
      npd_processed_vc0  <= npd_d;
      pd_num_vc0         <= pd_num_d;
      npd_num_vc0        <= npd_num_d;
      ph_buf_status_vc0  <= (p_cnt >= 6'(PH_THRESH));
      nph_buf_status_vc0 <= (np_cnt >= 6'(NPH_THRESH));
    end
  end

  assign pd_buf_status_vc0  = 1'b0;
  assign npd_buf_status_vc0 = 1'b0;

endmodule
